sig_byte_packer: RTL

//  Upstream capture stage for the PSK correlator hex dump path. Samples the 1-bit

---
 rtl/sig_byte_packer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sig_byte_packer.sv
// Decimating 1-bit sampler that packs 8 samples MSB-first into strobed bytes for a dump FIFO.
// Optional edge-triggered start is built when SIG_PACKER_EDGE_TRIG_EN is defined.
module sig_byte_packer #(
    parameter int unsigned DIV       = 48,
    parameter int unsigned CAP_BYTES = 1024,
    parameter int unsigned CW        = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sig_i,
    input  logic       arm_i,
    input  logic       full_i,
    output logic       stb_o,
    output logic [7:0] value_o,
    output logic       busy_o,
    output logic       ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CAP_CNT  = CW'(CAP_BYTES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic          sync1_q, sig_s_q;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]    sh_q, sh_d;
    logic [7:0]    value_q, value_d;
    logic          stb_q, stb_d;
    logic          ovf_q, ovf_d;

    logic          tick;
    logic          byte_tick;
    logic          start;
    logic          cap_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sig_s_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sig_s_q <= sync1_q;
        end
    end

`ifdef SIG_PACKER_EDGE_TRIG_EN
    logic sig_prev_q;
    logic trig_edge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_prev_q <= 1'b0;
        end else begin
            sig_prev_q <= sig_s_q;
        end
    end

    assign trig_edge = sig_s_q ^ sig_prev_q;
`endif

    assign tick      = (state_q == ST_CAPTURE) && (div_cnt_q == DIV_LAST);
    assign byte_tick = tick && (bit_cnt_q == 3'd7);
    assign start     = (state_q == ST_IDLE) && arm_i;
    // byte_cnt only reaches CAP_CNT in the cycle the last byte is strobed
    assign cap_done  = (CAP_BYTES != 0) && (state_q == ST_CAPTURE) && (byte_cnt_q == CAP_CNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
`ifdef SIG_PACKER_EDGE_TRIG_EN
                    state_d = ST_WAIT_TRIG;
`else
                    state_d = ST_CAPTURE;
`endif
                end
            end
            ST_WAIT_TRIG: begin
`ifdef SIG_PACKER_EDGE_TRIG_EN
                if (trig_edge) begin
                    state_d = ST_CAPTURE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_CAPTURE: begin
                if (cap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    // Divider, bit counter and shift register only run in CAPTURE; outside it they sit at zero
    always_comb begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sh_d      = '0;
        if ((state_q == ST_CAPTURE) && !cap_done) begin
            div_cnt_d = tick ? '0 : (div_cnt_q + CNT_ONE);
            bit_cnt_d = tick ? (bit_cnt_q + 3'd1) : bit_cnt_q;
            sh_d      = tick ? {sh_q[5:0], sig_s_q} : sh_q;
        end

        byte_cnt_d = byte_cnt_q;
        if (start) begin
            byte_cnt_d = '0;
        end else if (byte_tick) begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
        end

        ovf_d = ovf_q;
        if (start) begin
            ovf_d = 1'b0;
        end else if (byte_tick && full_i) begin
            ovf_d = 1'b1;
        end

        stb_d   = byte_tick && !full_i;
        value_d = stb_d ? {sh_q, sig_s_q} : value_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
            value_q    <= '0;
            stb_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            value_q    <= value_d;
            stb_q      <= stb_d;
            ovf_q      <= ovf_d;
        end
    end

    assign stb_o   = stb_q;
    assign value_o = value_q;
    assign ovf_o   = ovf_q;

endmodule
